vga_sync_decoder: RTL and testbench

Recovers pixel coordinates and frame timing from an incoming active-low hsync/vsync pair, the receive-side counterpart of the VGA timing generator. It measures line and frame periods, locks after repeated identical frames, and provides `pixel_x`/`pixel_y`/`active` to downstream capture or checker logic. All logic advances only on `clk_en` cycles, one pixel per qualified cycle.

---
 rtl/vga_sync_decoder.sv | 154 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: measures line/frame periods from active-low syncs,
// locks after repeated identical frames and decodes pixel coordinates.
// Define VGA_DEC_ERR_CNT_EN to add the saturating lock_loss_count output.
module vga_sync_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_PULSE = 96,
  parameter int H_BACK_PORCH = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_PULSE = 2,
  parameter int V_BACK_PORCH = 33,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [10:0] v_period
`ifdef VGA_DEC_ERR_CNT_EN
  ,
  output logic [7:0]  lock_loss_count
`endif
);

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_FIRST = 11'(H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [10:0] H_LAST  = 11'(H_SYNC_PULSE + H_BACK_PORCH + H_VISIBLE);
  localparam logic [10:0] V_FIRST = 11'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [10:0] V_LAST  = 11'(V_SYNC_PULSE + V_BACK_PORCH + V_VISIBLE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [10:0] h_cnt, v_cnt;
  logic [10:0] cand_h, cand_v;
  logic [3:0]  match_cnt;
  logic        vs_pend, line_clean;

  logic        h_fall, v_fall, frame_edge, h_sat, lock_lost;
  logic [10:0] h_meas, v_meas;
  logic        h_vis, v_vis;

  assign h_fall     = hs_s2 & ~hs_s1;
  assign v_fall     = vs_s2 & ~vs_s1;
  // a vsync edge arriving together with the hsync edge still closes the frame
  assign frame_edge = h_fall & (vs_pend | v_fall);
  assign h_meas     = h_cnt + 11'd1;
  assign v_meas     = v_cnt + 11'd1;
  // a line end on the saturated count is judged as a (bad) period, not as saturation
  assign h_sat      = (h_cnt == CNT_MAX) & ~h_fall;
  assign lock_lost  = (state == LOCKED) &
                      (h_sat | (h_fall & (h_meas != cand_h)) | (frame_edge & (v_meas != cand_v)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_s1       <= 1'b1;
      hs_s2       <= 1'b1;
      vs_s1       <= 1'b1;
      vs_s2       <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_period    <= '0;
      v_period    <= '0;
      cand_h      <= '0;
      cand_v      <= '0;
      match_cnt   <= '0;
      vs_pend     <= 1'b0;
      line_clean  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      state       <= SEARCH;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (clk_en) begin
        hs_s1 <= hsync;
        hs_s2 <= hs_s1;
        vs_s1 <= vsync;
        vs_s2 <= vs_s1;

        if (h_fall) begin
          h_cnt      <= '0;
          h_period   <= h_meas;
          line_start <= 1'b1;
          if (h_meas != h_period) line_clean <= 1'b0;
          if (frame_edge) begin
            v_cnt       <= '0;
            v_period    <= v_meas;
            vs_pend     <= 1'b0;
            frame_start <= 1'b1;
            line_clean  <= 1'b1;
          end else if (v_cnt != CNT_MAX) begin
            v_cnt <= v_cnt + 11'd1;
          end
        end else begin
          if (!h_sat) h_cnt <= h_cnt + 11'd1;
          if (v_fall) vs_pend <= 1'b1;
        end

        if (lock_lost || h_sat) begin
          state <= SEARCH;
        end else begin
          case (state)
            SEARCH: if (frame_edge) begin
              // stale candidate from a previous lock must not shortcut reacquisition
              state     <= MEASURE;
              cand_h    <= '0;
              cand_v    <= '0;
              match_cnt <= '0;
            end
            MEASURE: if (frame_edge) begin
              if (line_clean && (h_meas == cand_h) && (v_meas == cand_v)) begin
                match_cnt <= match_cnt + 4'd1;
                if (match_cnt + 4'd1 == LOCK_N) state <= LOCKED;
              end else begin
                cand_h    <= h_meas;
                cand_v    <= v_meas;
                match_cnt <= '0;
              end
            end
            LOCKED:  ;
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

`ifdef VGA_DEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      lock_loss_count <= '0;
    else if (clk_en && lock_lost && (lock_loss_count != 8'hFF))
      lock_loss_count <= lock_loss_count + 8'd1;
  end
`endif

  assign locked  = (state == LOCKED);
  assign h_vis   = (h_cnt >= H_FIRST) && (h_cnt < H_LAST);
  assign v_vis   = (v_cnt >= V_FIRST) && (v_cnt < V_LAST);
  assign active  = locked & h_vis & v_vis;
  assign pixel_x = active ? (h_cnt - H_FIRST) : '0;
  assign pixel_y = active ? (v_cnt - V_FIRST) : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 28x13 raster: the stimulus queues
// per-frame expectations, a negedge monitor checks them on every frame_start pulse.
module tb_vga_sync_decoder;

  localparam int HS = 4, HB = 3, HV = 16, HT = 28;
  localparam int VS = 2, VB = 3, VV = 6,  VT = 13;

  logic        clk = 1'b0;
  logic        reset_n, clk_en, hsync, vsync;
  logic [10:0] pixel_x, pixel_y, h_period, v_period;
  logic        active, line_start, frame_start, locked;
`ifdef VGA_DEC_ERR_CNT_EN
  logic [7:0]  lock_loss_count;
`endif

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
    .V_VISIBLE(VV), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_period(h_period), .v_period(v_period)
`ifdef VGA_DEC_ERR_CNT_EN
    , .lock_loss_count(lock_loss_count)
`endif
  );

  // expectation for the frame interval closed by one frame_start pulse
  typedef struct {
    bit cp;   // periods meaningful
    bit lk;
    int hp;
    int vp;
    int cnt;  // active pixels seen in the interval
    int ly;   // y of last active pixel
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_tab[21];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   a_cnt = 0, fx = 0, fy = 0, lx = 0, ly = 0, nb = 0;
  logic prev_ls = 1'b0, prev_fs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input bit cp, input bit lk, input int cnt, input int lyv);
    exp_t e;
    e.cp = cp; e.lk = lk; e.hp = HT; e.vp = VT; e.cnt = cnt; e.ly = lyv;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      a_cnt = 0; prev_ls = 1'b0; prev_fs = 1'b0;
    end else begin
      if (active && clk_en) begin
        if (a_cnt == 0) begin fx = int'(pixel_x); fy = int'(pixel_y); end
        lx = int'(pixel_x); ly = int'(pixel_y);
        a_cnt++;
      end
      if (line_start) check("line_start_width", 32'(prev_ls), 0);
      if (frame_start) begin
        check("frame_start_width", 32'(prev_fs), 0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame_start: got boundary %0d expected none", nb + 1);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("b%0d_locked", nb + 1), 32'(locked), 32'(mon_e.lk));
          if (mon_e.cp) begin
            check($sformatf("b%0d_h_period", nb + 1), 32'(h_period), mon_e.hp);
            check($sformatf("b%0d_v_period", nb + 1), 32'(v_period), mon_e.vp);
          end
          check($sformatf("b%0d_active_cnt", nb + 1), a_cnt, mon_e.cnt);
          if (mon_e.cnt > 0) begin
            check($sformatf("b%0d_first_x", nb + 1), fx, 0);
            check($sformatf("b%0d_first_y", nb + 1), fy, 0);
            check($sformatf("b%0d_last_x", nb + 1), lx, HV - 1);
            check($sformatf("b%0d_last_y", nb + 1), ly, mon_e.ly);
          end
        end
        nb++;
        a_cnt = 0;
      end
      prev_ls = line_start;
      prev_fs = frame_start;
    end
  end

  // one pixel: one qualified cycle, followed by an idle cycle at half rate
  task automatic pix(input bit h, input bit v, input bit half);
    hsync = h; vsync = v; clk_en = 1'b1;
    @(posedge clk); #1;
    if (half) begin
      clk_en = 1'b0;
      @(posedge clk); #1;
      clk_en = 1'b1;
    end
  endtask

  // 5: line 8 stretched; 10: 4 lines then hsync held high; 11-14: half rate with early
  // vsync; 15: one-clk reset mid-visible; 20: two lines to close frame 19
  task automatic gen_frame(input int f);
    bit h, v, half, early;
    int nl, len;
    half  = (f >= 11 && f <= 14);
    early = half;
    nl    = (f == 10) ? 4 : (f == 20) ? 2 : VT;
    for (int ln = 0; ln < nl; ln++) begin
      len = HT + ((f == 5 && ln == 8) ? 1 : 0);
      for (int p = 0; p < len; p++) begin
        h = (p >= HS);
        v = !((ln < VS) || (early && ln == VT - 1 && p >= HT - 3));
        if (f == 15 && ln == 7 && p == 11) begin
          check("pre_rst_active", 32'(active), 1);
          check("pre_rst_pixel_x", 32'(pixel_x), 2);
          check("pre_rst_pixel_y", 32'(pixel_y), 2);
          reset_n = 1'b0;
          pix(h, v, 1'b0);
          reset_n = 1'b1;
          check("rst_locked", 32'(locked), 0);
          check("rst_active", 32'(active), 0);
          check("rst_pixel_x", 32'(pixel_x), 0);
          check("rst_pixel_y", 32'(pixel_y), 0);
          check("rst_h_period", 32'(h_period), 0);
          check("rst_v_period", 32'(v_period), 0);
          check("rst_line_start", 32'(line_start), 0);
          check("rst_frame_start", 32'(frame_start), 0);
`ifdef VGA_DEC_ERR_CNT_EN
          check("rst_lock_loss_count", 32'(lock_loss_count), 0);
`endif
        end else begin
          pix(h, v, half);
        end
        if (f == 5 && ln == 9 && p == 0) check("stretch_still_locked", 32'(locked), 1);
        if (f == 5 && ln == 9 && p == 1) begin
          check("stretch_unlocked", 32'(locked), 0);
          check("stretch_active", 32'(active), 0);
        end
      end
    end
    if (f == 10) begin
      check("pre_hold_locked", 32'(locked), 1);
      repeat (2100) pix(1'b1, 1'b1, 1'b0);
      check("hold_unlocked", 32'(locked), 0);
      check("hold_active", 32'(active), 0);
`ifdef VGA_DEC_ERR_CNT_EN
      // one loss from the stretched line, one from saturation
      check("hold_lock_loss_count", 32'(lock_loss_count), 2);
`endif
    end
  endtask

  initial begin
    exp_tab[0]  = mk(0, 0, 0,  0);  // first boundary after reset
    exp_tab[1]  = mk(1, 0, 0,  0);
    exp_tab[2]  = mk(1, 0, 0,  0);
    exp_tab[3]  = mk(1, 1, 0,  0);  // 4th boundary locks
    exp_tab[4]  = mk(1, 1, 96, 5);
    exp_tab[5]  = mk(1, 1, 96, 5);
    exp_tab[6]  = mk(1, 0, 64, 3);  // stretched frame, lock lost after y=3
    exp_tab[7]  = mk(1, 0, 0,  0);
    exp_tab[8]  = mk(1, 0, 0,  0);
    exp_tab[9]  = mk(1, 1, 0,  0);
    exp_tab[10] = mk(1, 1, 96, 5);
    exp_tab[11] = mk(0, 0, 0,  0);  // closes the saturated interval
    exp_tab[12] = mk(1, 0, 0,  0);
    exp_tab[13] = mk(1, 0, 0,  0);
    exp_tab[14] = mk(1, 1, 0,  0);
    exp_tab[15] = mk(1, 1, 96, 5);  // half rate, same coordinates
    exp_tab[16] = mk(0, 0, 0,  0);  // first boundary after mid-frame reset
    exp_tab[17] = mk(1, 0, 0,  0);
    exp_tab[18] = mk(1, 0, 0,  0);
    exp_tab[19] = mk(1, 1, 0,  0);
    exp_tab[20] = mk(1, 1, 96, 5);

    reset_n = 1'b0; clk_en = 1'b1; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", 32'(locked), 0);
    check("reset_active", 32'(active), 0);
    check("reset_pixel_x", 32'(pixel_x), 0);
    check("reset_pixel_y", 32'(pixel_y), 0);
    check("reset_h_period", 32'(h_period), 0);
    check("reset_v_period", 32'(v_period), 0);
    check("reset_line_start", 32'(line_start), 0);
    check("reset_frame_start", 32'(frame_start), 0);
    reset_n = 1'b1;
    repeat (5) pix(1'b1, 1'b1, 1'b0);

    for (int f = 0; f <= 20; f++) begin
      exp_q.push_back(exp_tab[f]);
      gen_frame(f);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) pix(1'b1, 1'b1, 1'b0);
    repeat (4) pix(1'b1, 1'b1, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    check("boundaries_seen", nb, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
